// File: rtl/uart_tx_fifo.sv
// Transmit FIFO in front of a UART transmitter: buffers bytes at full clock rate and
// drains them one frame at a time through the send / tx_busy / tx_done handshake.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  clr_ovf,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  send,
    output logic [DATA_WIDTH-1:0] tx_data_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    state_t                state_q, state_d;
    logic                  send_q, send_d;
    logic                  overflow_q, overflow_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  push;
    logic                  pop;

    // Flags come straight from the registered count, so no input reaches them combinationally.
    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign send        = send_q;
    assign tx_data_out = tx_data_q;

    always_comb begin
        push = wr_en && !full;
        pop  = (state_q == IDLE) && !empty && !tx_busy;

        wp_d = push ? wp_q + 1'b1 : wp_q;
        rp_d = pop  ? rp_q + 1'b1 : rp_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        // A dropped write outranks a clear arriving in the same cycle.
        overflow_d = overflow_q;
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end

        send_d    = pop;
        tx_data_d = pop ? mem_q[rp_q] : tx_data_q;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (tx_done) begin
                    state_d = IDLE;
                end else if (tx_busy) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            send_q     <= 1'b0;
            overflow_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            state_q    <= state_d;
            send_q     <= send_d;
            overflow_q <= overflow_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage carries no reset; its contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural transmitter whose frame length
// is adjustable (0 = done pulse right after send, no busy phase).
module tb_uart_tx_fifo;

    logic       clk       = 1'b0;
    logic       reset     = 1'b0;
    logic       wr_en     = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       clr_ovf   = 1'b0;
    logic       hold_busy = 1'b0;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_busy;
    logic       tx_done   = 1'b0;
    logic       send;
    logic [7:0] tx_data_out;

    logic       model_busy = 1'b0;
    int         busy_cnt   = 0;
    int         frame_len  = 8;
    int         send_count = 0;
    int         proto_err  = 0;
    logic [7:0] rx_q [$];

    int tests = 0;
    int fails = 0;

    uart_tx_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_ovf    (clr_ovf),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .send       (send),
        .tx_data_out(tx_data_out)
    );

    always #5 clk = ~clk;

    assign tx_busy = model_busy | hold_busy;

    // Transmitter model: latches the byte on send, stays busy for frame_len cycles, then pulses done.
    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (send) begin
            send_count <= send_count + 1;
            rx_q.push_back(tx_data_out);
            if (model_busy) proto_err <= proto_err + 1;
            if (frame_len == 0) begin
                tx_done <= 1'b1;
            end else begin
                model_busy <= 1'b1;
                busy_cnt   <= frame_len;
            end
        end else if (model_busy) begin
            if (busy_cnt == 1) begin
                model_busy <= 1'b0;
                tx_done    <= 1'b1;
            end
            busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] data);
        wr_data = data;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_sends(input int target, input int budget, input string tag);
        int n = 0;
        while (send_count < target && n < budget) begin
            tick();
            n++;
        end
        check_output(tag, send_count, target);
    endtask

    task automatic check_seq(input int base, input int n, input logic [7:0] first, input string tag);
        check_output({tag, "_len"}, rx_q.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_q.size()) begin
                check_output($sformatf("%s_%0d", tag, i), rx_q[base + i], first + i[7:0]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_s;
        int base_r;
        int max_count;

        // Reset values
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check_output("rst_empty", empty, 1);
        check_output("rst_full", full, 0);
        check_output("rst_count", count, 0);
        check_output("rst_send", send, 0);
        check_output("rst_data", tx_data_out, 0);
        check_output("rst_ovf", overflow, 0);

        // Single byte: count at push edge, send and data on the following edge
        frame_len = 8;
        base_s = send_count;
        base_r = rx_q.size();
        push_byte(8'hA5);
        check_output("single_count_k", count, 1);
        check_output("single_empty_k", empty, 0);
        check_output("single_send_k", send, 0);
        tick();
        check_output("single_send_k1", send, 1);
        check_output("single_data_k1", tx_data_out, 8'hA5);
        check_output("single_count_k1", count, 0);
        tick();
        check_output("single_send_pulse", send, 0);
        check_output("single_data_hold", tx_data_out, 8'hA5);
        repeat (30) tick();
        check_output("single_one_send", send_count - base_s, 1);
        check_seq(base_r, 1, 8'hA5, "single_seq");

        // Burst of 16 into a held-busy transmitter, then drain in order
        base_s = send_count;
        base_r = rx_q.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(i[7:0]);
        check_output("burst_full", full, 1);
        check_output("burst_count", count, 16);
        check_output("burst_no_send", send_count - base_s, 0);
        hold_busy = 1'b0;
        wait_sends(base_s + 16, 1000, "burst_drain");
        repeat (frame_len + 5) tick();
        check_output("burst_sends", send_count - base_s, 16);
        check_output("burst_empty", empty, 1);
        check_seq(base_r, 16, 8'h00, "burst_seq");

        // Overflow set, clear, and set-wins-over-clear
        base_s = send_count;
        base_r = rx_q.size();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push_byte(8'h20 + i[7:0]);
        check_output("ovf_pre", overflow, 0);
        push_byte(8'hEE);
        check_output("ovf_set", overflow, 1);
        check_output("ovf_count", count, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("ovf_clear", overflow, 0);
        clr_ovf = 1'b1;
        push_byte(8'hEE);
        clr_ovf = 1'b0;
        check_output("ovf_set_wins", overflow, 1);
        check_output("ovf_count2", count, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_output("ovf_clear2", overflow, 0);
        hold_busy = 1'b0;
        wait_sends(base_s + 16, 1000, "ovf_drain");
        repeat (frame_len + 5) tick();
        check_output("ovf_sends", send_count - base_s, 16);
        check_seq(base_r, 16, 8'h20, "ovf_seq");

        // Streaming with concurrent push/pop through a fast transmitter; pointers wrap
        frame_len = 0;
        base_s = send_count;
        base_r = rx_q.size();
        max_count = 0;
        for (int i = 0; i < 40; i++) begin
            push_byte(8'h40 + i[7:0]);
            if (count > max_count) max_count = count;
            tick();
            if (count > max_count) max_count = count;
            tick();
            if (count > max_count) max_count = count;
        end
        wait_sends(base_s + 40, 500, "wrap_drain");
        repeat (5) tick();
        check_output("wrap_max_le16", (max_count <= 16), 1);
        check_output("wrap_no_ovf", overflow, 0);
        check_output("wrap_empty", empty, 1);
        check_seq(base_r, 40, 8'h40, "wrap_seq");

        // Asynchronous reset while waiting for tx_done with 5 bytes queued
        frame_len = 30;
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) push_byte(8'h80 + i[7:0]);
        hold_busy = 1'b0;
        repeat (4) tick();
        check_output("mid_count", count, 5);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_rst_count", count, 0);
        check_output("mid_rst_empty", empty, 1);
        check_output("mid_rst_send", send, 0);
        repeat (2) tick();
        reset = 1'b1;
        base_s = send_count;
        repeat (50) tick();
        check_output("mid_no_send", send_count - base_s, 0);
        check_output("mid_still_empty", empty, 1);
        base_r = rx_q.size();
        push_byte(8'h77);
        wait_sends(base_s + 1, 20, "mid_resume");
        check_seq(base_r, 1, 8'h77, "mid_seq");
        repeat (40) tick();

        check_output("proto_no_early_send", proto_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
